// File: rtl/prefix_adder_arb_pkg.sv
// prefix_adder_arb_pkg
//   Shared definitions for prefix_adder_arbiter and its sub-blocks:
//   datapath width, default requester count, the operand type, and the
//   round-robin pointer wrap helper.
package prefix_adder_arb_pkg;

  localparam int DATA_W      = 32;
  localparam int NUM_REQ_DEF = 4;

  typedef logic [DATA_W-1:0] data_t;

  // Index that follows idx in an n-entry ring. Wraps explicitly so that
  // non-power-of-2 ring sizes never produce an out-of-range pointer.
  function automatic int next_ptr(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/prefix_adder.sv
// Prefix_Adder
//   32-bit Kogge-Stone parallel-prefix adder, purely combinational.
//   Ports:
//     A, B  in   32  operands
//     Sum   out  32  A + B modulo 2^32 (no carry in, carry out dropped)
module Prefix_Adder (
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] Sum
);

  logic [31:0] p0;
  logic [31:0] g0;
  logic        unused_carry_out;

  assign p0 = A ^ B;
  assign g0 = A & B;

  // Five prefix levels with span 1, 2, 4, 8, 16. Zeros shifted into the low
  // bits leave already-resolved group generates untouched.
  genvar gi;
  for (gi = 0; gi < 5; gi++) begin : lvl
    logic [31:0] g_in;
    logic [31:0] p_in;
    logic [31:0] g_out;
    logic [31:0] p_out;
    if (gi == 0) begin : first
      assign g_in = g0;
      assign p_in = p0;
    end else begin : rest
      assign g_in = lvl[gi-1].g_out;
      assign p_in = lvl[gi-1].p_out;
    end
    assign g_out = g_in | (p_in & (g_in << (1 << gi)));
    assign p_out = p_in & (p_in << (1 << gi));
  end

  // Carry into bit i is the group generate of bits [i-1:0].
  assign Sum = p0 ^ {lvl[4].g_out[30:0], 1'b0};

  // Carry-out and final group propagate have no consumer.
  assign unused_carry_out = ^{lvl[4].g_out[31], lvl[4].p_out};

endmodule

// File: rtl/prefix_adder_arbiter_rr.sv
// rr_arbiter
//   Combinational round-robin arbiter. Grants the first asserted request
//   found when searching ptr, ptr+1, ... wrapping modulo N.
//   Ports:
//     req    in   N       request vector
//     ptr    in   log2 N  highest-priority index (must be < N)
//     grant  out  N       one-hot grant, or zero when req is zero
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  logic [N-1:0] rot;
  logic [N-1:0] rot_first;

  // Rotate so the priority index sits at bit 0, isolate the lowest set bit,
  // then rotate back into requester order.
  assign rot       = N'({req, req} >> ptr);
  assign rot_first = rot & ~(rot - N'(1));
  assign grant     = N'({rot_first, rot_first} << ptr >> N);

endmodule

// File: rtl/prefix_adder_arbiter.sv
// prefix_adder_arbiter
//   Shares one 32-bit Prefix_Adder among NUM_REQ requesters with
//   work-conserving round-robin arbitration and a registered, tagged result
//   behind a valid/ready handshake. One operation accepted per cycle.
//   Ports:
//     clk        in   1          clock
//     rst_n      in   1          asynchronous active-low reset
//     req_valid  in   NUM_REQ    per-requester operation valid
//     req_ready  out  NUM_REQ    per-requester accept, one-hot or zero
//     req_a      in   NUM_REQ*32 operand A, requester i at [32*i+31:32*i]
//     req_b      in   NUM_REQ*32 operand B, same packing
//     rsp_valid  out  1          result register holds a valid result
//     rsp_ready  in   1          consumer accepts the result
//     rsp_sum    out  32         registered A+B mod 2^32
//     rsp_ovf    out  1          signed overflow of the result
//                                (only with PREFIX_ADDER_ARB_OVF_EN defined)
//     rsp_id     out  ID_W       requester that produced rsp_sum
module prefix_adder_arbiter
  import prefix_adder_arb_pkg::*;
#(
  parameter  int NUM_REQ = NUM_REQ_DEF,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_W-1:0]         rsp_sum,
`ifdef PREFIX_ADDER_ARB_OVF_EN
  output logic                      rsp_ovf,
`endif
  output logic [ID_W-1:0]           rsp_id
);

  logic [ID_W-1:0]    rr_ptr_reg;
  logic               rsp_valid_reg;
  data_t              rsp_sum_reg;
  logic [ID_W-1:0]    rsp_id_reg;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               accept_en;
  logic               transfer;
  data_t              sel_a;
  data_t              sel_b;
  data_t              sum_next;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr_reg),
    .grant (grant)
  );

  // Nothing may be accepted while reset is held, even though the output
  // register already reads empty.
  assign accept_en = rst_n & (~rsp_valid_reg | rsp_ready);
  assign req_ready = grant & {NUM_REQ{accept_en}};
  // grant only ever points at a valid requester, so any ready is a transfer.
  assign transfer  = |req_ready;

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) grant_idx = ID_W'(i);
    end
  end

  assign sel_a = req_a[DATA_W*grant_idx +: DATA_W];
  assign sel_b = req_b[DATA_W*grant_idx +: DATA_W];

  Prefix_Adder u_add (
    .A   (sel_a),
    .B   (sel_b),
    .Sum (sum_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_reg    <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_sum_reg   <= '0;
      rsp_id_reg    <= '0;
    end else if (transfer) begin
      rsp_valid_reg <= 1'b1;
      rsp_sum_reg   <= sum_next;
      rsp_id_reg    <= grant_idx;
      rr_ptr_reg    <= ID_W'(next_ptr(int'(grant_idx), NUM_REQ));
    end else if (rsp_ready) begin
      rsp_valid_reg <= 1'b0;
    end
  end

  assign rsp_valid = rsp_valid_reg;
  assign rsp_sum   = rsp_sum_reg;
  assign rsp_id    = rsp_id_reg;

`ifdef PREFIX_ADDER_ARB_OVF_EN
  logic rsp_ovf_reg;
  logic ovf_next;

  // Like-signed operands whose sum flips sign.
  assign ovf_next = (sel_a[DATA_W-1] == sel_b[DATA_W-1]) &&
                    (sum_next[DATA_W-1] != sel_a[DATA_W-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_ovf_reg <= 1'b0;
    end else if (transfer) begin
      rsp_ovf_reg <= ovf_next;
    end
  end

  assign rsp_ovf = rsp_ovf_reg;
`endif

endmodule

// File: tb/tb_prefix_adder_arbiter.sv
// tb_prefix_adder_arbiter
//   Directed bench for prefix_adder_arbiter (NUM_REQ=4). A cycle-level
//   behavioural model tracks priority, the result slot and handshakes; a
//   negedge process compares the DUT against it every cycle, and the
//   directed sequence adds hand-computed literal expectations.
//   Build with PREFIX_ADDER_ARB_OVF_EN defined to cover rsp_ovf.
module tb_prefix_adder_arbiter;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req_valid = '0;
  logic [N-1:0]  req_ready;
  logic [N*32-1:0] req_a = '0;
  logic [N*32-1:0] req_b = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [31:0]   rsp_sum;
  logic [1:0]    rsp_id;
`ifdef PREFIX_ADDER_ARB_OVF_EN
  logic          rsp_ovf;
`endif

  int tests = 0;
  int fails = 0;

  prefix_adder_arbiter #(.NUM_REQ(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
`ifdef PREFIX_ADDER_ARB_OVF_EN
    .rsp_ovf   (rsp_ovf),
`endif
    .rsp_id    (rsp_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_ptr   = 0;
  bit          m_valid = 1'b0;
  logic [31:0] m_sum   = '0;
  int          m_id    = 0;
  bit          m_ovf   = 1'b0;
  int          m_g;
  bit          m_acc;
  logic [31:0] m_a;
  logic [31:0] m_b;

  // First valid requester at or after the priority index, -1 if none.
  function automatic int model_grant();
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] model_ready();
    int g;
    g = model_grant();
    if (rst_n && (!m_valid || rsp_ready) && g >= 0) return N'(1) << g;
    return '0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ptr = 0; m_valid = 1'b0; m_sum = '0; m_id = 0; m_ovf = 1'b0;
    end else begin
      m_g   = model_grant();
      m_acc = !m_valid || rsp_ready;
      if (m_acc && m_g >= 0) begin
        m_a     = req_a[32*m_g +: 32];
        m_b     = req_b[32*m_g +: 32];
        m_sum   = m_a + m_b;
        m_ovf   = (m_a[31] == m_b[31]) && (m_sum[31] != m_a[31]);
        m_id    = m_g;
        m_valid = 1'b1;
        m_ptr   = (m_g + 1) % N;
      end else if (rsp_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("cyc_req_ready", 32'(req_ready), 32'(model_ready()));
    check("cyc_rsp_valid", 32'(rsp_valid), 32'(m_valid));
    check("cyc_rsp_sum",   rsp_sum,        m_sum);
    check("cyc_rsp_id",    32'(rsp_id),    32'(m_id));
`ifdef PREFIX_ADDER_ARB_OVF_EN
    check("cyc_rsp_ovf",   32'(rsp_ovf),   32'(m_ovf));
`endif
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ramp();
    for (int i = 0; i < N; i++) begin
      req_a[32*i +: 32] = 32'(i);
      req_b[32*i +: 32] = 32'h10;
    end
  endtask

  initial begin
    // Reset held with every requester valid.
    req_valid = '1;
    set_ramp();
    rsp_ready = 1'b1;
    tick(); tick();
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_sum",   rsp_sum,        32'd0);
    check("rst_id",    32'(rsp_id),    32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);

    rst_n = 1'b1;
    #1;
    check("first_grant", 32'(req_ready), 32'b0001);

    // Round robin, one result per cycle: ids 0,1,2,3,0.
    for (int k = 0; k < 5; k++) begin
      tick();
      check("rr_valid", 32'(rsp_valid), 32'd1);
      check("rr_id",    32'(rsp_id),    32'(k % N));
      check("rr_sum",   rsp_sum,        32'h10 + 32'(k % N));
    end

    // Single request from 2 with carry-out wrap; priority now at 1.
    req_valid = 4'b0100;
    req_a[64 +: 32] = 32'hFFFF_FFFF;
    req_b[64 +: 32] = 32'h0000_0001;
    #1;
    check("single_ready", 32'(req_ready), 32'b0100);
    tick();
    check("single_valid", 32'(rsp_valid), 32'd1);
    check("single_sum",   rsp_sum,        32'h0000_0000);
    check("single_id",    32'(rsp_id),    32'd2);

    // Search now begins at 3.
    req_valid = '1;
    set_ramp();
    #1;
    check("search_from_3", 32'(req_ready), 32'b1000);
    tick();
    check("r3_id",  32'(rsp_id), 32'd3);
    check("r3_sum", rsp_sum,     32'h13);

    // Backpressure for three cycles.
    rsp_ready = 1'b0;
    #1;
    check("stall_ready0", 32'(req_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall_valid", 32'(rsp_valid), 32'd1);
      check("stall_id",    32'(rsp_id),    32'd3);
      check("stall_sum",   rsp_sum,        32'h13);
      check("stall_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    #1;
    check("unstall_ready", 32'(req_ready), 32'b0001);
    tick();
    check("unstall_id",  32'(rsp_id), 32'd0);
    check("unstall_sum", rsp_sum,     32'h10);

    // Drain with no new work, then idle: priority must not rotate.
    req_valid = '0;
    tick();
    check("drain_valid", 32'(rsp_valid), 32'd0);
    check("drain_sum",   rsp_sum,        32'h10);
    tick(); tick();
    req_valid = '1;
    #1;
    check("idle_no_rot", 32'(req_ready), 32'b0010);
    tick();
    check("idle_id", 32'(rsp_id), 32'd1);

    // Asynchronous reset between edges while a result is held.
    rsp_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_valid", 32'(rsp_valid), 32'd0);
    check("async_sum",   rsp_sum,        32'd0);
    check("async_id",    32'(rsp_id),    32'd0);
    rsp_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    #1;
    check("ptr_after_rst", 32'(req_ready), 32'b0001);
    tick();
    check("post_rst_id", 32'(rsp_id), 32'd0);

`ifdef PREFIX_ADDER_ARB_OVF_EN
    req_valid = 4'b0001;
    req_a[0 +: 32] = 32'h7FFF_FFFF;
    req_b[0 +: 32] = 32'h0000_0001;
    tick();
    check("ovf_sum", rsp_sum,         32'h8000_0000);
    check("ovf_set", 32'(rsp_ovf),    32'd1);
    req_a[0 +: 32] = 32'hFFFF_FFFF;
    tick();
    check("ovf_wrap_sum", rsp_sum,      32'h0000_0000);
    check("ovf_clear",    32'(rsp_ovf), 32'd0);
`endif

    req_valid = '0;
    tick(); tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
